bcd_to_binary: RTL and testbench
================================

# bcd_to_binary

Sequential converter from packed BCD to unsigned binary; the inverse of the DPM's binary-to-BCD path. It accepts a multi-digit BCD word over a valid/ready handshake and processes one decimal digit per clock, most-significant digit first, using Horner's rule (acc = acc*10 + digit). It sits between the front-panel/host numeric entry path and the frequency/DDS control logic. It also serves as a round-trip checker for the binary-to-BCD block in simulation.

## Interface

- DECIMAL_DIGITS, 11: number of BCD digits in i_bcd.
- OUTPUT_WIDTH, 37: width of o_binary. 37 bits holds all 11-digit values, since 99,999,999,999 < 2^37.
- i_clk  input  1  sole clock; all logic is rising-edge.
- i_resetn  input  1  asynchronous, active-low reset.
- i_bcd  input  4*DECIMAL_DIGITS  packed BCD; digit k occupies bits [4k+3:4k], with digit DECIMAL_DIGITS-1 as the most significant.
- i_valid  input  1  input word present; sampled only while o_ready=1.
- o_ready  output  1  high in IDLE only.
- o_binary  output  OUTPUT_WIDTH  result; holds its value until the next completion.
- o_valid  output  1  one-cycle pulse marking a new o_binary.
- o_error  output  1  valid with o_valid; set if any input digit was >9.
- o_overflow  output  1  valid with o_valid; set if the true result is ≥ 2^OUTPUT_WIDTH.

## Operation

- The state machine has two states: IDLE and CONVERT. The reset state is IDLE.
- IDLE: o_ready=1.
  - On i_valid=1 the block captures i_bcd into the digit shift register.
  - It also clears acc, the digit counter, the error flag and the overflow flag.
  - Next state is CONVERT.
- CONVERT: o_ready=0.
  - Each cycle, acc <= acc*10 + top digit, where acc*10 = (acc<<3)+(acc<<1).
  - The shift register then moves left by 4 bits and the counter increments.
  - A top digit >9 sets the sticky error flag. That digit is still accumulated at its raw value (0xA-0xF = 10-15), so the result is deterministic.
  - The block computes in OUTPUT_WIDTH+4 bits. Any nonzero bit above OUTPUT_WIDTH-1 sets the sticky overflow flag, and acc is then truncated to OUTPUT_WIDTH bits (the result is modulo 2^OUTPUT_WIDTH).
  - When the final digit is processed:
    - o_binary <= final acc.
    - o_valid <= 1.
    - o_error and o_overflow <= their final flag values.
    - Next state is IDLE.
- o_error and o_overflow are registered alongside o_valid. They hold until the next completion.
- i_bcd and i_valid are ignored in CONVERT. Upstream may change i_bcd once the transfer has been accepted.
- Asynchronous reset, including mid-conversion, forces:
  - state = IDLE and o_ready = 1;
  - o_valid = 0, o_binary = 0, o_error = 0, o_overflow = 0;
  - acc, shift register and counter = 0.
  
  The in-flight conversion is discarded and no o_valid is produced for it.

## Timing

- An input is accepted at rising edge N when i_valid=1 and o_ready=1.
- o_ready is low from edge N to edge N+DECIMAL_DIGITS, and high again after edge N+DECIMAL_DIGITS.
- o_valid is high for exactly one cycle, from edge N+DECIMAL_DIGITS to edge N+DECIMAL_DIGITS+1. Latency is DECIMAL_DIGITS cycles (11 by default).
- A new word may be accepted at edge N+DECIMAL_DIGITS+1, which is the same edge where o_valid drops. Sustained throughput is one conversion per DECIMAL_DIGITS+1 cycles.
- o_ready is a pure decode of the state register, with no combinational path from i_valid.
- o_binary changes only on the o_valid edge. It is stable for at least DECIMAL_DIGITS+1 cycles between updates.

## Test plan

- Default parameters, i_bcd = 0x00_1234567890 pulsed for one cycle: o_valid appears exactly 11 cycles after acceptance with o_binary = 1234567890, o_error = 0 and o_overflow = 0. o_ready is low for the 11 intervening edges.
- Boundary values, each checked independently:
  - i_bcd = all 9s gives o_binary = 99,999,999,999.
  - i_bcd = 0 gives o_binary = 0.
  
  Repeat over 1000 random valid BCD words, checking each against the decimal reference and against round-trip through binary_to_bcd.
- Invalid digit: i_bcd = 0x000_0000001A gives o_error = 1 and o_binary = 20 (1*10+10). The following conversion, 0x000_00000042, gives o_error = 0 and o_binary = 42.
- Overflow with DECIMAL_DIGITS=3, OUTPUT_WIDTH=8:
  - 0x255 gives 255 with o_overflow = 0.
  - 0x256 gives 0 with o_overflow = 1.
  - 0x999 gives 999 mod 256 = 231 with o_overflow = 1.
- Back-to-back: i_valid held high with a changing i_bcd. The block accepts exactly every 12 cycles, produces one o_valid per accepted word, ignores the values presented while busy, and loses no word.
- Reset: assert i_resetn=0 for 3 ns, five cycles into a conversion of 0x12345678901. All outputs go to 0 immediately, with o_ready = 1, and no o_valid follows. A fresh conversion of 7 then returns 7 on schedule.

Source files
------------

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to unsigned binary converter. It handles one decimal digit
// per clock, most-significant digit first, using acc = acc*10 + digit.
module bcd_to_binary #(
  parameter int DECIMAL_DIGITS = 11,
  parameter int OUTPUT_WIDTH   = 37
) (
  input  logic                        i_clk,
  input  logic                        i_resetn,
  input  logic [4*DECIMAL_DIGITS-1:0] i_bcd,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic [OUTPUT_WIDTH-1:0]     o_binary,
  output logic                        o_valid,
  output logic                        o_error,
  output logic                        o_overflow
);

  localparam int BW = 4 * DECIMAL_DIGITS;
  localparam int CW = $clog2(DECIMAL_DIGITS + 1);
  localparam int XW = OUTPUT_WIDTH + 4;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t                  state_q;
  logic [BW-1:0]           sr_q;
  logic [OUTPUT_WIDTH-1:0] acc_q;
  logic [CW-1:0]           cnt_q;
  logic                    err_q;
  logic                    ovf_q;

  logic [3:0]              digit;
  logic [XW-1:0]           wide;
  logic [OUTPUT_WIDTH-1:0] acc_d;
  logic                    err_d;
  logic                    ovf_d;
  logic                    last;

  // The wide product keeps 4 extra bits so that overflow can be seen before acc is truncated.
  always_comb begin
    digit = sr_q[BW-1 -: 4];
    wide  = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
          + {{OUTPUT_WIDTH{1'b0}}, digit};
    acc_d = wide[OUTPUT_WIDTH-1:0];
    err_d = err_q | (digit > 4'd9);
    ovf_d = ovf_q | (|wide[XW-1:OUTPUT_WIDTH]);
    last  = (cnt_q == CW'(DECIMAL_DIGITS - 1));
  end

  assign o_ready = (state_q == IDLE);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      o_binary   <= '0;
      o_valid    <= 1'b0;
      o_error    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            sr_q    <= i_bcd;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          acc_q <= acc_d;
          sr_q  <= sr_q << 4;
          cnt_q <= cnt_q + CW'(1);
          err_q <= err_d;
          ovf_q <= ovf_d;
          if (last) begin
            o_binary   <= acc_d;
            o_valid    <= 1'b1;
            o_error    <= err_d;
            o_overflow <= ovf_d;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Randomised self-checking bench for bcd_to_binary. It uses a default 11-digit
// instance and a 3-digit/8-bit instance for the overflow cases.
module tb_bcd_to_binary;

  logic        clk;
  logic        rstn;
  logic [43:0] bcd;
  logic        vld;
  logic        rdy;
  logic [36:0] bin;
  logic        ov;
  logic        er;
  logic        ovf;

  logic [11:0] s_bcd;
  logic        s_vld;
  logic        s_rdy;
  logic [7:0]  s_bin;
  logic        s_ov;
  logic        s_er;
  logic        s_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  bcd_to_binary dut (
    .i_clk(clk), .i_resetn(rstn), .i_bcd(bcd), .i_valid(vld),
    .o_ready(rdy), .o_binary(bin), .o_valid(ov), .o_error(er), .o_overflow(ovf)
  );

  bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(8)) dut_small (
    .i_clk(clk), .i_resetn(rstn), .i_bcd(s_bcd), .i_valid(s_vld),
    .o_ready(s_rdy), .o_binary(s_bin), .o_valid(s_ov), .o_error(s_er), .o_overflow(s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: the value is the sum of digit_k * 10^k, reduced modulo 2^w.
  function automatic void ref_calc(input logic [43:0] b, input int nd, input int w,
                                   output longint unsigned val, output bit err, output bit ovf_o);
    longint unsigned v = 0;
    longint unsigned p = 1;
    err = 1'b0;
    for (int k = 0; k < nd; k++) begin
      int unsigned d = 32'(b[4*k +: 4]);
      v += longint'(d) * p;
      p *= 10;
      if (d > 9) err = 1'b1;
    end
    ovf_o = (v >= (64'd1 << w));
    val   = v % (64'd1 << w);
  endfunction

  function automatic logic [43:0] rand_bcd();
    logic [43:0] r = '0;
    for (int k = 0; k < 11; k++) r[4*k +: 4] = 4'($urandom_range(9, 0));
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) check({tag, "_ready_timeout"}, 64'(rdy), 64'd1);
  endtask

  task automatic run_main(input logic [43:0] b, input string tag);
    longint unsigned ev;
    bit ee, eo;
    bit bad = 1'b0;
    logic [63:0] junk;
    wait_ready(tag);
    vld = 1'b1;
    bcd = b;
    @(posedge clk);
    #1;
    vld  = 1'b0;
    junk = {$urandom, $urandom};
    bcd  = junk[43:0];
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      if (k < 11 && (rdy || ov)) bad = 1'b1;
    end
    ref_calc(b, 11, 37, ev, ee, eo);
    check({tag, "_busy"}, 64'(bad), 64'd0);
    check({tag, "_valid"}, 64'(ov), 64'd1);
    check({tag, "_ready"}, 64'(rdy), 64'd1);
    check({tag, "_bin"}, 64'(bin), ev);
    check({tag, "_err"}, 64'(er), 64'(ee));
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(ov), 64'd0);
  endtask

  task automatic run_small(input logic [11:0] b, input string tag);
    longint unsigned ev;
    bit ee, eo;
    bit bad = 1'b0;
    @(negedge clk);
    s_vld = 1'b1;
    s_bcd = b;
    @(posedge clk);
    #1;
    s_vld = 1'b0;
    s_bcd = 12'(~b);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (k < 3 && (s_rdy || s_ov)) bad = 1'b1;
    end
    ref_calc({32'd0, b}, 3, 8, ev, ee, eo);
    check({tag, "_busy"}, 64'(bad), 64'd0);
    check({tag, "_valid"}, 64'(s_ov), 64'd1);
    check({tag, "_bin"}, 64'(s_bin), ev);
    check({tag, "_err"}, 64'(s_er), 64'(ee));
    check({tag, "_ovf"}, 64'(s_ovf), 64'(eo));
  endtask

  initial begin
    logic [43:0]     q[$];
    logic [43:0]     b;
    logic [63:0]     t;
    longint unsigned ev;
    bit              ee, eo;
    int              last_acc, n_acc, n_out;
    bit              seen;

    rstn  = 1'b0;
    vld   = 1'b0;
    bcd   = '0;
    s_vld = 1'b0;
    s_bcd = '0;
    #12;
    check("rst_ready", 64'(rdy), 64'd1);
    check("rst_valid", 64'(ov), 64'd0);
    check("rst_bin", 64'(bin), 64'd0);
    check("rst_err", 64'(er), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_small_ready", 64'(s_rdy), 64'd1);
    #8 rstn = 1'b1;

    run_main(44'h001234567890, "basic");
    check("basic_exact", 64'(bin), 64'd1234567890);
    run_main(44'h99999999999, "all9");
    check("all9_exact", 64'(bin), 64'd99999999999);
    run_main(44'h0, "zero");
    run_main(44'h0000000001A, "baddigit");
    check("baddigit_exact", 64'(bin), 64'd20);
    check("baddigit_flag", 64'(er), 64'd1);
    run_main(44'h00000000042, "after_bad");
    check("after_bad_flag", 64'(er), 64'd0);

    run_small(12'h255, "s255");
    check("s255_exact", {s_ovf, s_bin}, {1'b0, 8'd255});
    run_small(12'h256, "s256");
    check("s256_exact", {s_ovf, s_bin}, {1'b1, 8'd0});
    run_small(12'h999, "s999");
    check("s999_exact", {s_ovf, s_bin}, {1'b1, 8'd231});

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(9, 0) == 0) begin
        t = {$urandom, $urandom};
        b = t[43:0];
      end else begin
        b = rand_bcd();
      end
      run_main(b, "rand");
    end

    // Back-to-back: i_valid held high while i_bcd changes every cycle.
    wait_ready("b2b");
    vld = 1'b1;
    bcd = rand_bcd();
    last_acc = -1;
    n_acc = 0;
    n_out = 0;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      if (ov) begin
        if (q.size() == 0) check("b2b_extra_valid", 64'd1, 64'd0);
        else begin
          ref_calc(q.pop_front(), 11, 37, ev, ee, eo);
          check("b2b_bin", 64'(bin), ev);
          n_out++;
        end
      end
      if (rdy && vld) begin
        q.push_back(bcd);
        if (last_acc >= 0) check("b2b_interval", 64'(c - last_acc), 64'd12);
        last_acc = c;
        n_acc++;
      end
      @(posedge clk);
      #1;
      bcd = rand_bcd();
      if (c == 61) vld = 1'b0;
    end
    check("b2b_accepts", 64'(n_acc), 64'd6);
    check("b2b_outputs", 64'(n_out), 64'(n_acc));
    check("b2b_drained", 64'(q.size()), 64'd0);

    // Reset in the middle of a conversion.
    run_main(44'h99999999999, "pre_rst");
    @(negedge clk);
    vld = 1'b1;
    bcd = 44'h12345678901;
    @(posedge clk);
    #1;
    vld = 1'b0;
    repeat (5) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst_ready", 64'(rdy), 64'd1);
    check("midrst_valid", 64'(ov), 64'd0);
    check("midrst_bin", 64'(bin), 64'd0);
    check("midrst_err", 64'(er), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    #2 rstn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ov) seen = 1'b1;
    end
    check("midrst_no_valid", 64'(seen), 64'd0);
    run_main(44'h7, "after_rst");
    check("after_rst_exact", 64'(bin), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
